// File: rtl/bram_heap_pkg.sv
// Shared types and helpers for the RAM-per-level binary heap priority queue.
package bram_heap_pkg;

  localparam int unsigned CMP_W = 64;

  typedef enum logic [1:0] {
    NOP     = 2'b00,
    PUSH    = 2'b01,
    POP     = 2'b10,
    REPLACE = 2'b11
  } heap_op_e;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_LAST,
    FETCH,
    UPDATE
  } heap_state_e;

  // Strict ordering: equal values are never better.
  function automatic logic better(input logic [CMP_W-1:0] a,
                                  input logic [CMP_W-1:0] b,
                                  input logic             max_mode);
    return max_mode ? (a > b) : (a < b);
  endfunction

  function automatic int unsigned floor_log2(input logic [31:0] v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) r = unsigned'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/rams_tdp_rf_rf.sv
// True dual-port read-first block RAM, one-cycle registered read on each port.
module rams_tdp_rf_rf #(
  parameter int unsigned DW    = 16,
  parameter int unsigned AW    = 1,
  parameter int unsigned DEPTH = 2
) (
  input  logic          clk,
  input  logic          ena,
  input  logic          enb,
  input  logic          wea,
  input  logic          web,
  input  logic [AW-1:0] addra,
  input  logic [AW-1:0] addrb,
  input  logic [DW-1:0] dia,
  input  logic [DW-1:0] dib,
  output logic [DW-1:0] doa,
  output logic [DW-1:0] dob
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (ena) begin
      doa <= mem[addra];
      if (wea) mem[addra] <= dia;
    end
    if (enb) begin
      dob <= mem[addrb];
      if (web) mem[addrb] <= dib;
    end
  end

endmodule

// File: rtl/bram_heap_queue.sv
// Binary-heap priority queue, one RAM per tree level, single root-to-leaf traversal engine.
// Optional sticky illegal-op flag enabled by defining HEAP_ERR_EN.
module bram_heap_queue
  import bram_heap_pkg::*;
#(
  parameter int unsigned QUEUE_SIZE = 31,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned MAX_HEAP   = 1
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic                            i_valid,
  output logic                            o_ready,
  input  logic [1:0]                      i_op,
  input  logic [DATA_WIDTH-1:0]           i_data,
  output logic [DATA_WIDTH-1:0]           o_data,
  output logic                            o_empty,
  output logic                            o_full,
  output logic [$clog2(QUEUE_SIZE+1)-1:0] o_count,
  output logic                            o_err
);

  localparam int unsigned D   = $clog2(QUEUE_SIZE + 1);
  localparam int unsigned NW  = D + 1;
  localparam int unsigned LW  = $clog2(D + 1);
  localparam int unsigned CW  = D;
  localparam int unsigned AWM = (D > 1) ? D - 1 : 1;
  localparam logic        MODE = (MAX_HEAP != 0);

  heap_state_e           state_q, state_d;
  logic [NW-1:0]         node_q, node_d, target_q, target_d;
  logic [LW-1:0]         level_q, level_d, lt_q, lt_d;
  logic [DATA_WIDTH-1:0] carry_q, carry_d, data_q, data_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  is_push_q, is_push_d, load_q, load_d;
  logic                  ready_q, ready_d, empty_q, empty_d, full_q, full_d;

  logic [LW-1:0]         lvl_a_c, lvl_b_c, clvl_c;
  logic                  en_a_c, we_a_c, en_b_c, push_go_c;
  logic [AWM-1:0]        addr_a_c, addr_b_c;
  logic [NW-1:0]         left_c, right_c, best_idx_c;
  logic [DATA_WIDTH-1:0] wdata_c, lc_c, rc_c, best_c;
  logic                  has_l_c, has_r_c;
  logic [DATA_WIDTH-1:0] rd_a [D];
  logic [DATA_WIDTH-1:0] rd_b [D];

  function automatic logic bt(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
    return better(CMP_W'(a), CMP_W'(b), MODE);
  endfunction

  always_comb begin
    state_d   = state_q;
    node_d    = node_q;
    target_d  = target_q;
    level_d   = level_q;
    lt_d      = lt_q;
    carry_d   = carry_q;
    data_d    = data_q;
    count_d   = count_q;
    is_push_d = is_push_q;
    load_d    = load_q;
    push_go_c = 1'b0;
    en_a_c    = 1'b0;
    we_a_c    = 1'b0;
    en_b_c    = 1'b0;
    wdata_c   = carry_q;
    left_c    = {node_q[NW-2:0], 1'b0};
    right_c   = {node_q[NW-2:0], 1'b1};
    lvl_a_c   = level_q;
    lvl_b_c   = level_q + LW'(1);
    addr_a_c  = node_q[AWM-1:0];
    addr_b_c  = right_c[AWM-1:0];
    clvl_c    = (level_q < LW'(D - 1)) ? level_q + LW'(1) : level_q;
    has_l_c   = left_c <= NW'(count_q);
    has_r_c   = right_c <= NW'(count_q);
    lc_c      = rd_a[clvl_c];
    rc_c      = rd_b[clvl_c];
    // Child tie goes to the left child.
    if (has_r_c && bt(rc_c, lc_c)) begin
      best_c     = rc_c;
      best_idx_c = right_c;
    end else begin
      best_c     = lc_c;
      best_idx_c = left_c;
    end

    case (state_q)
      IDLE: begin
        if (i_valid) begin
          case (heap_op_e'(i_op))
            PUSH: push_go_c = !full_q;
            POP: begin
              if (!empty_q) begin
                count_d = count_q - CW'(1);
                if (count_q != CW'(1)) begin
                  target_d  = NW'(count_q);
                  lt_d      = LW'(floor_log2(32'(count_q)));
                  node_d    = NW'(1);
                  level_d   = '0;
                  is_push_d = 1'b0;
                  load_d    = 1'b1;
                  state_d   = LOAD_LAST;
                end
              end
            end
            REPLACE: begin
              if (empty_q) begin
                push_go_c = 1'b1;
              end else begin
                carry_d   = i_data;
                node_d    = NW'(1);
                level_d   = '0;
                is_push_d = 1'b0;
                load_d    = 1'b0;
                state_d   = FETCH;
              end
            end
            default: ;
          endcase
        end
        if (push_go_c) begin
          count_d   = count_q + CW'(1);
          target_d  = NW'(count_q) + NW'(1);
          lt_d      = LW'(floor_log2(32'(count_q) + 32'd1));
          carry_d   = i_data;
          node_d    = NW'(1);
          level_d   = '0;
          is_push_d = 1'b1;
          load_d    = 1'b0;
          state_d   = FETCH;
        end
      end
      LOAD_LAST: begin
        en_a_c   = 1'b1;
        lvl_a_c  = lt_q;
        addr_a_c = target_q[AWM-1:0];
        state_d  = FETCH;
      end
      FETCH: begin
        if (load_q) begin
          carry_d = rd_a[lt_q];
          load_d  = 1'b0;
        end
        if (is_push_q) begin
          en_a_c = (node_q != target_q);
        end else begin
          en_a_c   = (level_q < LW'(D - 1));
          en_b_c   = en_a_c;
          lvl_a_c  = level_q + LW'(1);
          addr_a_c = left_c[AWM-1:0];
        end
        state_d = UPDATE;
      end
      UPDATE: begin
        if (is_push_q) begin
          if (node_q == target_q) begin
            we_a_c  = 1'b1;
            state_d = IDLE;
          end else begin
            // Carry the loser of (carry, node) further down the insert path.
            if (bt(carry_q, rd_a[level_q])) begin
              we_a_c  = 1'b1;
              carry_d = rd_a[level_q];
            end
            level_d = level_q + LW'(1);
            node_d  = target_q >> (lt_q - level_q - LW'(1));
            state_d = FETCH;
          end
        end else begin
          we_a_c = 1'b1;
          if (has_l_c && bt(best_c, carry_q)) begin
            wdata_c = best_c;
            node_d  = best_idx_c;
            level_d = level_q + LW'(1);
            state_d = FETCH;
          end else begin
            state_d = IDLE;
          end
        end
        en_a_c = we_a_c;
      end
      default: state_d = IDLE;
    endcase

    if (we_a_c && (lvl_a_c == '0)) data_d = wdata_c;
    empty_d = (count_d == '0);
    full_d  = (count_d == CW'(QUEUE_SIZE));
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      node_q    <= '0;
      target_q  <= '0;
      level_q   <= '0;
      lt_q      <= '0;
      carry_q   <= '0;
      data_q    <= '0;
      count_q   <= '0;
      is_push_q <= 1'b0;
      load_q    <= 1'b0;
      ready_q   <= 1'b1;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      node_q    <= node_d;
      target_q  <= target_d;
      level_q   <= level_d;
      lt_q      <= lt_d;
      carry_q   <= carry_d;
      data_q    <= data_d;
      count_q   <= count_d;
      is_push_q <= is_push_d;
      load_q    <= load_d;
      ready_q   <= ready_d;
      empty_q   <= empty_d;
      full_q    <= full_d;
    end
  end

  assign o_ready = ready_q;
  assign o_data  = data_q;
  assign o_empty = empty_q;
  assign o_full  = full_q;
  assign o_count = count_q;

`ifdef HEAP_ERR_EN
  logic err_q, err_d, illegal_c;

  always_comb begin
    illegal_c = (state_q == IDLE) && i_valid &&
                (((heap_op_e'(i_op) == PUSH) && full_q) || ((heap_op_e'(i_op) == POP) && empty_q));
    err_d     = err_q | illegal_c;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

  // Level L holds nodes 2^L .. 2^(L+1)-1; address is the index without its leading one.
  for (genvar l = 0; l < D; l++) begin : g_level
    localparam int unsigned AW = (l == 0) ? 1 : l;
    logic [AW-1:0] ram_addr_a, ram_addr_b;
    logic          hit_a, hit_b;

    assign hit_a = (lvl_a_c == LW'(l));
    assign hit_b = (lvl_b_c == LW'(l));

    if (l == 0) begin : g_root
      assign ram_addr_a = '0;
      assign ram_addr_b = '0;
    end else begin : g_node
      assign ram_addr_a = addr_a_c[AW-1:0];
      assign ram_addr_b = addr_b_c[AW-1:0];
    end

    rams_tdp_rf_rf #(
      .DW   (DATA_WIDTH),
      .AW   (AW),
      .DEPTH(1 << l)
    ) u_ram (
      .clk  (CLK),
      .ena  (en_a_c && hit_a),
      .enb  (en_b_c && hit_b),
      .wea  (we_a_c && hit_a),
      .web  (1'b0),
      .addra(ram_addr_a),
      .addrb(ram_addr_b),
      .dia  (wdata_c),
      .dib  ('0),
      .doa  (rd_a[l]),
      .dob  (rd_b[l])
    );
  end

endmodule

// File: tb/tb_bram_heap_queue.sv
// Directed bench for bram_heap_queue: a max-heap and a min-heap instance, capacity 7.
module tb_bram_heap_queue;

  localparam int unsigned QS = 7;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = $clog2(QS + 1);
  localparam logic [1:0]  P  = 2'b01;
  localparam logic [1:0]  O  = 2'b10;
  localparam logic [1:0]  R  = 2'b11;
`ifdef HEAP_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  typedef struct {
    logic [1:0]    op;
    logic [DW-1:0] din;
    logic          chk_ret;
    logic [DW-1:0] ret;
    logic          chk_data;
    logic [DW-1:0] data;
    int            count;
    int            busy;
  } vec_t;

  logic          clk;
  logic          rst   [2];
  logic          valid [2];
  logic [1:0]    op    [2];
  logic [DW-1:0] din   [2];
  logic          rdy   [2];
  logic [DW-1:0] dout  [2];
  logic          empty [2];
  logic          full  [2];
  logic          err   [2];
  logic [CW-1:0] cnt   [2];

  int tests;
  int fails;
  vec_t qmax[$];
  vec_t qmin[$];

  bram_heap_queue #(.QUEUE_SIZE(QS), .DATA_WIDTH(DW), .MAX_HEAP(1)) u_max (
    .CLK(clk), .RST(rst[0]), .i_valid(valid[0]), .o_ready(rdy[0]), .i_op(op[0]),
    .i_data(din[0]), .o_data(dout[0]), .o_empty(empty[0]), .o_full(full[0]),
    .o_count(cnt[0]), .o_err(err[0])
  );

  bram_heap_queue #(.QUEUE_SIZE(QS), .DATA_WIDTH(DW), .MAX_HEAP(0)) u_min (
    .CLK(clk), .RST(rst[1]), .i_valid(valid[1]), .o_ready(rdy[1]), .i_op(op[1]),
    .i_data(din[1]), .o_data(dout[1]), .o_empty(empty[1]), .o_full(full[1]),
    .o_count(cnt[1]), .o_err(err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic vec_t mk(input logic [1:0] o, input int d, input logic cr, input int r,
                              input logic cd, input int dv, input int c, input int b);
    vec_t v;
    v.op = o; v.din = DW'(d); v.chk_ret = cr; v.ret = DW'(r);
    v.chk_data = cd; v.data = DW'(dv); v.count = c; v.busy = b;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Issue one op at a negedge; returns the top at acceptance and the busy-cycle count.
  task automatic do_op(input int s, input logic [1:0] o, input logic [DW-1:0] d,
                       output logic [DW-1:0] ret, output int busy);
    int guard;
    guard = 0;
    while (!rdy[s] && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    ret      = dout[s];
    valid[s] = 1'b1;
    op[s]    = o;
    din[s]   = d;
    @(negedge clk);
    valid[s] = 1'b0;
    op[s]    = 2'b00;
    din[s]   = '0;
    busy     = 0;
    while (!rdy[s] && busy < 100) begin
      @(negedge clk);
      busy++;
    end
  endtask

  task automatic run_table(input int s, input string tag, input vec_t v[$]);
    logic [DW-1:0] r;
    int            b;
    foreach (v[i]) begin
      do_op(s, v[i].op, v[i].din, r, b);
      if (v[i].chk_ret)  check($sformatf("%s[%0d] popped", tag, i), 32'(r), 32'(v[i].ret));
      if (v[i].chk_data) check($sformatf("%s[%0d] o_data", tag, i), 32'(dout[s]), 32'(v[i].data));
      check($sformatf("%s[%0d] o_count", tag, i), 32'(cnt[s]), 32'(v[i].count));
      check($sformatf("%s[%0d] busy", tag, i), 32'(b), 32'(v[i].busy));
      check($sformatf("%s[%0d] o_empty", tag, i), 32'(empty[s]), 32'(v[i].count == 0));
      check($sformatf("%s[%0d] o_full", tag, i), 32'(full[s]), 32'(v[i].count == int'(QS)));
    end
  endtask

  task automatic check_reset(input int s, input string tag);
    check({tag, " rst o_ready"}, 32'(rdy[s]), 32'd1);
    check({tag, " rst o_data"},  32'(dout[s]), 32'd0);
    check({tag, " rst o_empty"}, 32'(empty[s]), 32'd1);
    check({tag, " rst o_full"},  32'(full[s]), 32'd0);
    check({tag, " rst o_count"}, 32'(cnt[s]), 32'd0);
    check({tag, " rst o_err"},   32'(err[s]), 32'd0);
  endtask

  initial begin
    int            pb [7];
    logic [DW-1:0] r;
    int            b;
    tests = 0;
    fails = 0;
    pb = '{2, 4, 4, 6, 6, 6, 6};
    for (int s = 0; s < 2; s++) begin
      rst[s] = 1'b1; valid[s] = 1'b0; op[s] = 2'b00; din[s] = '0;
    end

    // Max-heap: push/pop ordering, pop-to-empty, illegal ops, fill to capacity.
    qmax.push_back(mk(P, 5, 0, 0, 1, 5, 1, 2));
    qmax.push_back(mk(P, 9, 0, 0, 1, 9, 2, 4));
    qmax.push_back(mk(P, 2, 0, 0, 1, 9, 3, 4));
    qmax.push_back(mk(P, 7, 0, 0, 1, 9, 4, 6));
    qmax.push_back(mk(O, 0, 1, 9, 1, 7, 3, 5));
    qmax.push_back(mk(O, 0, 1, 7, 1, 5, 2, 5));
    qmax.push_back(mk(O, 0, 1, 5, 1, 2, 1, 3));
    qmax.push_back(mk(O, 0, 1, 2, 0, 0, 0, 0));
    qmax.push_back(mk(O, 0, 0, 0, 0, 0, 0, 0));
    qmax.push_back(mk(R, 3, 0, 0, 1, 3, 1, 2));
    qmax.push_back(mk(O, 0, 1, 3, 0, 0, 0, 0));
    for (int k = 1; k <= 7; k++) qmax.push_back(mk(P, k, 0, 0, 1, k, k, pb[k-1]));
    qmax.push_back(mk(P, 8, 0, 0, 1, 7, 7, 0));
    qmax.push_back(mk(O, 0, 1, 7, 1, 6, 6, 5));
    qmax.push_back(mk(O, 0, 1, 6, 1, 5, 5, 5));

    // Min-heap: ordering, replace sift, pop refill.
    qmin.push_back(mk(P, 5, 0, 0, 1, 5, 1, 2));
    qmin.push_back(mk(P, 9, 0, 0, 1, 5, 2, 4));
    qmin.push_back(mk(P, 2, 0, 0, 1, 2, 3, 4));
    qmin.push_back(mk(P, 7, 0, 0, 1, 2, 4, 6));
    qmin.push_back(mk(R, 8, 1, 2, 1, 5, 4, 4));
    qmin.push_back(mk(O, 0, 1, 5, 1, 7, 3, 5));

    repeat (3) @(negedge clk);
    check_reset(0, "max");
    check_reset(1, "min");
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(negedge clk);

    run_table(0, "max", qmax);
    check("max o_err after illegal ops", 32'(err[0]), 32'(ERR_EXP));
    run_table(1, "min", qmin);
    check("min o_err all legal", 32'(err[1]), 32'd0);

    // Reset in the middle of a pop sift on the min heap.
    valid[1] = 1'b1; op[1] = O;
    @(negedge clk);
    valid[1] = 1'b0; op[1] = 2'b00;
    check("mid busy before reset", 32'(rdy[1]), 32'd0);
    @(negedge clk);
    rst[1] = 1'b1;
    #1;
    check("mid rst o_count", 32'(cnt[1]), 32'd0);
    check("mid rst o_ready", 32'(rdy[1]), 32'd1);
    check("mid rst o_empty", 32'(empty[1]), 32'd1);
    check("mid rst o_data",  32'(dout[1]), 32'd0);
    @(negedge clk);
    rst[1] = 1'b0;
    @(negedge clk);
    do_op(1, P, 16'd6, r, b);
    check("post rst push o_data",  32'(dout[1]), 32'd6);
    check("post rst push o_count", 32'(cnt[1]), 32'd1);
    check("post rst push busy",    32'(b), 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
